multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle RV32I control FSM, successor to the single-cycle decoder. Sequences
//  each instruction over 3-5 states and drives the shared-memory/ALU datapath
//  (IR, OldPC, A/B, ALUOut, Data regs). Adds optional BNE, JAL and memory wait states.
//  Sits between instruction register/ALU flags and datapath muxes/strobes.
// PARAMETERS
//  ENABLE_BNE  1  1: funct3=001 branches on ~zero; 0: only BEQ (funct3=000).
//  ENABLE_JAL  1  1: op 1101111 decoded; 0: treated as illegal.
//  MEM_WAIT    1  1: FETCH/MEMREAD/MEMWRITE stall until mem_ready; 0: ignore it.
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  async active-high; forces state=FETCH
//  op         in   7  IR[6:0]
//  funct3     in   3  IR[14:12]
//  funct7b5   in   1  IR[30], forwarded into ALU decode
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  unified memory access done this cycle
//  PCWrite    out  1  PC register enable
//  AdrSrc     out  1  0: PC, 1: ALUOut to memory address
//  MemWrite   out  1  memory write strobe
//  IRWrite    out  1  IR and OldPC enable
//  ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out  2  00 PC, 01 OldPC, 10 A(rs1)
//  ALUSrcB    out  2  00 B(rs2), 01 ImmExt, 10 constant 4
//  ALUOp      out  2  00 add, 01 sub/compare, 10 funct-decoded
//  ImmSrc     out  2  00 I, 01 S, 10 B, 11 J; combinational from op
//  RegWrite   out  1  register file write enable
//  illegal    out  1  sticky; set on undecodable op in DECODE
//  state      out  4  current state encoding, for debug/verification
// BEHAVIOUR
//  States (4'd): FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECR6
//  EXECI7 ALUWB8 BRANCH9 JAL10. Encodings 11-15 go to FETCH next cycle.
//  Transitions: FETCH->DECODE (when mem_ready or MEM_WAIT=0, else stay).
//  DECODE: lw/sw->MEMADR; R->EXECR; I-ALU->EXECI; branch->BRANCH;
//  jal->JAL; other->FETCH with illegal<=1.
//  MEMADR: lw->MEMREAD, sw->MEMWRITE. MEMREAD->MEMWB on ready.
//  MEMWRITE->FETCH on ready. MEMWB->FETCH. EXECR/EXECI->ALUWB. ALUWB->FETCH.
//  BRANCH->FETCH. JAL->ALUWB.
//  Per-state outputs; unlisted outputs are 0:
//  FETCH: AdrSrc0 IRWrite ALUSrcA00 ALUSrcB10 ALUOp00 ResultSrc10 PCUpdate.
//    IRWrite and PCUpdate assert only in the cycle FETCH exits.
//  DECODE: ALUSrcA01 ALUSrcB01 ALUOp00 (branch/jump target into ALUOut).
//  MEMADR: ALUSrcA10 ALUSrcB01 ALUOp00.
//  MEMREAD: AdrSrc1 ResultSrc00. MEMWB: ResultSrc01 RegWrite.
//  MEMWRITE: AdrSrc1 ResultSrc00 MemWrite (held every cycle in state).
//  EXECR: SrcA10 SrcB00 ALUOp10. EXECI: SrcA10 SrcB01 ALUOp10.
//  ALUWB: ResultSrc00 RegWrite.
//  BRANCH: SrcA10 SrcB00 ALUOp01 ResultSrc00 Branch.
//  JAL: SrcA01 SrcB10 ALUOp00 ResultSrc00 PCUpdate.
//  PCWrite = PCUpdate | (Branch & taken). taken = zero when funct3=000;
//  ~zero when funct3=001 and ENABLE_BNE; otherwise 0 (no branch, no flag).
//  Reset (async): state=FETCH, illegal=0. While reset=1, PCWrite, IRWrite,
//  MemWrite and RegWrite are forced 0; mux selects show FETCH values.
//  Reset mid-instruction discards it; the first fetch follows deassertion.
//  illegal clears only on reset; the FSM keeps running after it is set.
//  ImmSrc and the mux selects are pure functions of op/state (no latency).
//  Strobes are registered by the datapath on the next clk edge.
// TESTING
//  1 add x3,x1,x2, mem_ready=1: FETCH,DECODE,EXECR,ALUWB; RegWrite=1 in cycle 4 only.
//  2 lw, mem_ready low 3 cycles in MEMREAD: 8 cycles total; MemWrite=0; RegWrite in MEMWB.
//  3 sw, MEM_WAIT=1, ready after 2: MemWrite high 2 cycles in MEMWRITE, then FETCH.
//  4 beq zero=1 -> PCWrite=1 in BRANCH; bne zero=1 -> 0; ENABLE_BNE=0, bne zero=0 -> 0.
//  5 jal: FETCH,DECODE,JAL(PCWrite=1),ALUWB(ResultSrc=00,RegWrite=1); ImmSrc=11.
//  6 op=7'h7F -> illegal=1 after DECODE, back to FETCH; reset in MEMWRITE -> MemWrite=0 at once.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-memory datapath and drives its mux selects and write strobes.
module multicycle_control_unit #(
  parameter bit ENABLE_BNE = 1'b1,
  parameter bit ENABLE_JAL = 1'b1,
  parameter bit MEM_WAIT   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t st, st_nxt;
  logic   illegal_set;
  logic   mem_go;
  logic   is_lw, is_sw, is_r, is_i, is_br, is_jal;
  logic   taken;
  logic   pc_update, branch, ir_write, mem_write, reg_write;

  // funct7b5 only matters to the downstream ALU decoder
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  assign mem_go = mem_ready || !MEM_WAIT;
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_r   = (op == OP_RTYP);
  assign is_i   = (op == OP_ITYP);
  assign is_br  = (op == OP_BR);
  assign is_jal = (op == OP_JAL) && ENABLE_JAL;
  assign state  = 4'(st);

  // Branch condition; unsupported funct3 values never redirect the PC
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ENABLE_BNE && !zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Next-state logic
  always_comb begin
    st_nxt      = S_FETCH;
    illegal_set = 1'b0;
    case (st)
      S_FETCH:    st_nxt = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) st_nxt = S_MEMADR;
        else if (is_r)      st_nxt = S_EXECR;
        else if (is_i)      st_nxt = S_EXECI;
        else if (is_br)     st_nxt = S_BRANCH;
        else if (is_jal)    st_nxt = S_JAL;
        else begin
          st_nxt      = S_FETCH;
          illegal_set = 1'b1;
        end
      end
      S_MEMADR: begin
        if (is_lw)      st_nxt = S_MEMREAD;
        else if (is_sw) st_nxt = S_MEMWRITE;
        else            st_nxt = S_FETCH;
      end
      S_MEMREAD:  st_nxt = mem_go ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: st_nxt = mem_go ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    st_nxt = S_FETCH;
      S_EXECR:    st_nxt = S_ALUWB;
      S_EXECI:    st_nxt = S_ALUWB;
      S_ALUWB:    st_nxt = S_FETCH;
      S_BRANCH:   st_nxt = S_FETCH;
      S_JAL:      st_nxt = S_ALUWB;
      default:    st_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      st <= st_nxt;
      if (illegal_set) illegal <= 1'b1;
    end
  end

  // Per-state datapath controls; strobes are suppressed while reset is held
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (st)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_go;
        pc_update = mem_go;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    PCWrite  = !reset && (pc_update || (branch && taken));
    IRWrite  = !reset && ir_write;
    MemWrite = !reset && mem_write;
    RegWrite = !reset && reg_write;
  end

endmodule
